usb_ep_protocol_ctrl: RTL and testbench

USB_EP_PROTOCOL_CTRL -- requirements
Module: usb_ep_protocol_ctrl

---
 rtl/usb_ep_pkg.sv | 37 +++
 rtl/usb_toggle_bank.sv | 28 ++
 rtl/usb_ep_protocol_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_usb_ep_protocol_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared packet encodings and controller state for the USB bulk endpoint protocol engine.
package usb_ep_pkg;

    typedef enum logic [2:0] {
        RxIdle  = 3'd0,
        RxIn    = 3'd1,
        RxOut   = 3'd2,
        RxAck   = 3'd3,
        RxError = 3'd4,
        RxDone  = 3'd5,
        RxNak   = 3'd6
    } rx_pkt_e;

    typedef enum logic [2:0] {
        TxIdle  = 3'd0,
        TxData0 = 3'd1,
        TxData1 = 3'd2,
        TxNak   = 3'd3,
        TxAck   = 3'd4,
        TxStall = 3'd5
    } tx_pkt_e;

    typedef enum logic [3:0] {
        StIdle,
        StInData,
        StInHs,
        StInNak,
        StOutData,
        StOutSkip,
        StOutAck,
        StOutDup,
        StOutNak,
        StOutErr,
        StStall
    } state_e;

endpackage

// File: rtl/usb_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits; a clear request overrides a same-cycle flip.
module usb_toggle_bank #(
    parameter int unsigned NumEp = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumEp-1:0] flip_i,
    input  logic [NumEp-1:0] clr_i,
    output logic [NumEp-1:0] toggle_o
);

    logic [NumEp-1:0] toggle_q, toggle_d;

    always_comb begin
        toggle_d = (toggle_q ^ flip_i) & ~clr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle_o = toggle_q;

endmodule

// File: rtl/usb_ep_protocol_ctrl.sv
// Bulk endpoint protocol controller: sequences IN/OUT transactions, handshakes,
// data toggles, halts and timeouts for up to eight endpoints.
module usb_ep_protocol_ctrl
    import usb_ep_pkg::*;
#(
    parameter int unsigned NUM_EP      = 2,
    parameter int unsigned MAX_PKT     = 64,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned EPW         = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
    parameter int unsigned OW          = $clog2(MAX_PKT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rx_packet,
    input  logic [EPW-1:0]    rx_ep,
    input  logic              rx_data1,
    input  logic [OW-1:0]     buffer_occupancy,
    input  logic [OW-1:0]     tx_packet_data_size,
    input  logic              buffer_reserved,
    input  logic [EPW-1:0]    tx_ep,
    input  logic [NUM_EP-1:0] ep_halt,
    input  logic [NUM_EP-1:0] toggle_clr,
    output logic              rx_data_ready,
    output logic              rx_transfer_active,
    output logic              rx_error,
    output logic              tx_transfer_active,
    output logic              tx_error,
    output logic              d_mode,
    output logic              clear,
    output logic [2:0]        tx_packet,
    output logic [EPW-1:0]    active_ep,
    output logic [NUM_EP-1:0] toggle
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [EPW-1:0] active_ep_q, active_ep_d;
    logic           tx_err_q, tx_err_d;
    logic           clr_pulse_q, clr_pulse_d;
    logic           flip_en;
    logic           timeout;
    logic           rx_ep_ok;
    logic           cur_toggle;
    rx_pkt_e        rx_pkt;
    tx_pkt_e        tx_pkt;

    assign rx_pkt     = rx_pkt_e'(rx_packet);
    assign rx_ep_ok   = 32'(rx_ep) < NUM_EP;
    assign timeout    = (cnt_q == CW'(TIMEOUT_CYC));
    assign cur_toggle = toggle[active_ep_q];

    usb_toggle_bank #(
        .NumEp(NUM_EP)
    ) u_toggle_bank (
        .clk_i   (clk),
        .rst_i   (rst),
        .flip_i  (NUM_EP'(flip_en) << active_ep_q),
        .clr_i   (toggle_clr),
        .toggle_o(toggle)
    );

    always_comb begin
        state_d     = state_q;
        active_ep_d = active_ep_q;
        flip_en     = 1'b0;
        tx_err_d    = 1'b0;
        clr_pulse_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_ep_ok && rx_pkt == RxIn) begin
                    active_ep_d = rx_ep;
                    if (ep_halt[rx_ep]) begin
                        state_d = StStall;
                    end else if (buffer_reserved && tx_ep == rx_ep &&
                                 buffer_occupancy == tx_packet_data_size) begin
                        state_d = StInData;
                    end else begin
                        state_d = StInNak;
                    end
                end else if (rx_ep_ok && rx_pkt == RxOut) begin
                    active_ep_d = rx_ep;
                    state_d = (ep_halt[rx_ep] || buffer_occupancy != '0) ? StOutSkip : StOutData;
                end
            end
            StInData: state_d = StInHs;
            StInHs: begin
                if (rx_pkt == RxAck) begin
                    flip_en     = 1'b1;
                    clr_pulse_d = 1'b1;
                    state_d     = StIdle;
                end else if (rx_pkt == RxNak || timeout) begin
                    // Leave toggle and staged buffer alone so the host retry resends it.
                    tx_err_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StOutData: begin
                if (rx_pkt == RxError || 32'(buffer_occupancy) > MAX_PKT || timeout) begin
                    state_d = StOutErr;
                end else if (rx_pkt == RxDone) begin
                    state_d = (rx_data1 == cur_toggle) ? StOutAck : StOutDup;
                end
            end
            StOutSkip: begin
                if (rx_pkt == RxDone) begin
                    state_d = ep_halt[active_ep_q] ? StStall : StOutNak;
                end else if (rx_pkt == RxError || timeout) begin
                    state_d = StOutErr;
                end
            end
            StOutAck: begin
                flip_en = 1'b1;
                state_d = StIdle;
            end
            StInNak, StOutDup, StOutErr, StOutNak, StStall: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            active_ep_q <= '0;
            tx_err_q    <= 1'b0;
            clr_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_ep_q <= active_ep_d;
            tx_err_q    <= tx_err_d;
            clr_pulse_q <= clr_pulse_d;
        end
    end

    always_comb begin
        rx_data_ready      = 1'b0;
        rx_transfer_active = 1'b0;
        rx_error           = 1'b0;
        tx_transfer_active = 1'b0;
        d_mode             = 1'b0;
        clear              = clr_pulse_q;
        tx_pkt             = TxIdle;
        unique case (state_q)
            StIdle:    tx_transfer_active = buffer_reserved;
            StInData: begin
                tx_pkt             = cur_toggle ? TxData1 : TxData0;
                tx_transfer_active = 1'b1;
            end
            StInHs:    tx_transfer_active = 1'b1;
            StInNak:   tx_pkt = TxNak;
            StOutData: begin
                rx_transfer_active = 1'b1;
                d_mode             = 1'b1;
            end
            StOutSkip: begin
                clear  = 1'b1;
                d_mode = 1'b1;
            end
            StOutAck: begin
                tx_pkt        = TxAck;
                rx_data_ready = 1'b1;
            end
            StOutDup: begin
                tx_pkt = TxAck;
                clear  = 1'b1;
            end
            StOutErr: begin
                rx_error = 1'b1;
                clear    = 1'b1;
            end
            StOutNak: begin
                tx_pkt   = TxNak;
                rx_error = 1'b1;
            end
            StStall:   tx_pkt = TxStall;
            default:   tx_pkt = TxIdle;
        endcase
    end

    assign tx_packet = tx_pkt;
    assign tx_error  = tx_err_q;
    assign active_ep = active_ep_q;

endmodule

// File: tb/tb_usb_ep_protocol_ctrl.sv
// Directed self-checking bench for usb_ep_protocol_ctrl with the default parameters.
module tb_usb_ep_protocol_ctrl;

    localparam logic [2:0] P_IDLE = 3'd0, P_IN = 3'd1, P_OUT = 3'd2, P_ACK = 3'd3,
                           P_ERROR = 3'd4, P_DONE = 3'd5;
    localparam logic [2:0] T_IDLE = 3'd0, T_DATA0 = 3'd1, T_DATA1 = 3'd2, T_NAK = 3'd3,
                           T_ACK = 3'd4, T_STALL = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_packet;
    logic       rx_ep;
    logic       rx_data1;
    logic [6:0] buffer_occupancy;
    logic [6:0] tx_packet_data_size;
    logic       buffer_reserved;
    logic       tx_ep;
    logic [1:0] ep_halt;
    logic [1:0] toggle_clr;
    logic       rx_data_ready, rx_transfer_active, rx_error;
    logic       tx_transfer_active, tx_error, d_mode, clear;
    logic [2:0] tx_packet;
    logic       active_ep;
    logic [1:0] toggle;

    int tests_run    = 0;
    int tests_failed = 0;

    usb_ep_protocol_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .rx_packet          (rx_packet),
        .rx_ep              (rx_ep),
        .rx_data1           (rx_data1),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data_size(tx_packet_data_size),
        .buffer_reserved    (buffer_reserved),
        .tx_ep              (tx_ep),
        .ep_halt            (ep_halt),
        .toggle_clr         (toggle_clr),
        .rx_data_ready      (rx_data_ready),
        .rx_transfer_active (rx_transfer_active),
        .rx_error           (rx_error),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .d_mode             (d_mode),
        .clear              (clear),
        .tx_packet          (tx_packet),
        .active_ep          (active_ep),
        .toggle             (toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are read at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic token(input logic [2:0] pid, input logic ep);
        rx_packet = pid;
        rx_ep     = ep;
        tick();
        rx_packet = P_IDLE;
    endtask

    initial begin
        int n;
        rst = 1'b1; rx_packet = P_IDLE; rx_ep = 1'b0; rx_data1 = 1'b0;
        buffer_occupancy = '0; tx_packet_data_size = '0; buffer_reserved = 1'b0;
        tx_ep = 1'b0; ep_halt = '0; toggle_clr = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_tx_packet", tx_packet, T_IDLE);
        check("rst_toggle", toggle, 2'b00);
        check("rst_outputs", {clear, tx_error, rx_error, d_mode, rx_data_ready,
                              rx_transfer_active, tx_transfer_active, active_ep}, 0);

        // IN ep1 with matching staged data, host ACKs
        buffer_reserved = 1'b1; tx_ep = 1'b1;
        buffer_occupancy = 7'd8; tx_packet_data_size = 7'd8;
        #1 check("idle_tx_active", tx_transfer_active, 1);
        token(P_IN, 1'b1);
        check("in1_data0", tx_packet, T_DATA0);
        check("in1_active_ep", active_ep, 1);
        tick();
        check("in1_hs_quiet", tx_packet, T_IDLE);
        rx_packet = P_ACK; tick(); rx_packet = P_IDLE;
        check("in1_clear", clear, 1);
        check("in1_toggle", toggle, 2'b10);
        tick();
        check("in1_clear_pulse", clear, 0);
        buffer_reserved = 1'b0; buffer_occupancy = '0;

        // OUT ep0 DATA0 accepted, then duplicate DATA0
        token(P_OUT, 1'b0);
        check("out0_d_mode", d_mode, 1);
        check("out0_rx_active", rx_transfer_active, 1);
        rx_packet = P_DONE; rx_data1 = 1'b0; tick(); rx_packet = P_IDLE;
        check("out0_ack", tx_packet, T_ACK);
        check("out0_ready", rx_data_ready, 1);
        tick();
        check("out0_toggle", toggle, 2'b11);
        token(P_OUT, 1'b0);
        rx_packet = P_DONE; rx_data1 = 1'b0; tick(); rx_packet = P_IDLE;
        check("dup_ack", tx_packet, T_ACK);
        check("dup_clear", clear, 1);
        check("dup_no_ready", rx_data_ready, 0);
        tick();
        check("dup_toggle_kept", toggle, 2'b11);

        // IN ep0 with no host handshake: timeout then retry
        buffer_reserved = 1'b1; tx_ep = 1'b0;
        buffer_occupancy = 7'd8; tx_packet_data_size = 7'd8;
        token(P_IN, 1'b0);
        check("in0_data1", tx_packet, T_DATA1);
        tick();
        n = 0;
        while (tx_error !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("timeout_window", (n >= 255 && n <= 257), 1);
        check("timeout_no_clear", clear, 0);
        check("timeout_toggle", toggle, 2'b11);
        tick();
        check("tx_error_one_cycle", tx_error, 0);
        token(P_IN, 1'b0);
        check("retry_same_pid", tx_packet, T_DATA1);
        tick();
        rx_packet = P_ACK; tick(); rx_packet = P_IDLE;
        check("retry_ack_toggle", toggle, 2'b10);
        buffer_reserved = 1'b0; buffer_occupancy = '0;
        tick();

        // Halted ep1 stalls both directions; ep0 still works
        ep_halt = 2'b10;
        token(P_IN, 1'b1);
        check("halt_in_stall", tx_packet, T_STALL);
        tick();
        check("stall_one_cycle", tx_packet, T_IDLE);
        token(P_OUT, 1'b1);
        check("halt_out_skip_clear", clear, 1);
        rx_packet = P_DONE; tick(); rx_packet = P_IDLE;
        check("halt_out_stall", tx_packet, T_STALL);
        tick();
        token(P_OUT, 1'b0);
        check("ep0_not_halted", rx_transfer_active, 1);
        rx_packet = P_DONE; rx_data1 = 1'b0; tick(); rx_packet = P_IDLE;
        check("ep0_ack", tx_packet, T_ACK);
        tick();
        check("ep0_toggle", toggle, 2'b11);
        ep_halt = 2'b00;

        // Oversize OUT payload, then clear racing an ACK flip
        token(P_OUT, 1'b0);
        buffer_occupancy = 7'd65;
        tick();
        check("oversize_rx_error", rx_error, 1);
        check("oversize_clear", clear, 1);
        check("oversize_no_hs", tx_packet, T_IDLE);
        buffer_occupancy = '0;
        tick();
        check("oversize_toggle", toggle, 2'b11);
        token(P_OUT, 1'b0);
        rx_packet = P_DONE; rx_data1 = 1'b1; tick(); rx_packet = P_IDLE;
        check("flip_ack", tx_packet, T_ACK);
        toggle_clr = 2'b01; tick(); toggle_clr = 2'b00;
        check("clr_beats_flip", toggle, 2'b10);

        // Reset in the middle of an OUT transfer
        token(P_OUT, 1'b0);
        rst = 1'b1; rx_packet = P_DONE; rx_data1 = 1'b0;
        tick();
        rst = 1'b0; rx_packet = P_IDLE;
        check("midrst_tx_packet", tx_packet, T_IDLE);
        check("midrst_toggle", toggle, 2'b00);
        check("midrst_rx_active", rx_transfer_active, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
